// File: rtl/button_decoder.sv
// button_decoder: debounces four switches, emits one-shot direction strobes and start/game-reset combo strobes
module button_decoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic [3:0] i_Switch,
  output logic [3:0] o_Switch,
  output logic       o_Up_Pulse,
  output logic       o_Dn_Pulse,
  output logic       o_Lt_Pulse,
  output logic       o_Rt_Pulse,
  output logic       o_Start,
  output logic       o_Game_Reset,
  output logic       o_Combo_Active
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ARM_START, ARM_RST, LOCKOUT} state_t;
  logic [3:0] sync_1, sync_2, sw_q, dir;
  logic [DW-1:0] db_cnt [4];
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic hold_last, fire_start, fire_rst;
  state_t state, state_nxt;
  assign hold_last = hold_cnt == HW'(HOLD_CYCLES - 1);
  assign o_Combo_Active = state != IDLE;
  // two-flop synchronizer on the raw switches
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= i_Switch;
      sync_2 <= sync_1;
    end
  // per-bit debounce: accept a change only after it persists DEBOUNCE_CYCLES cycles
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      o_Switch <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (sync_2[i] == o_Switch[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          o_Switch[i] <= sync_2[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + 1'b1;
    end
  // combo FSM state and hold counter register
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      state <= IDLE;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  // combo FSM next state: hold counter runs only while the combo pattern is held
  always_comb begin
    state_nxt = state;
    hold_nxt = '0;
    case (state)
      IDLE: state_nxt = o_Switch == 4'b1111 ? ARM_RST : o_Switch == 4'b0111 ? ARM_START : IDLE;
      ARM_START:
        if (o_Switch == 4'b0111) begin
          state_nxt = hold_last ? LOCKOUT : ARM_START;
          hold_nxt = hold_last ? '0 : hold_cnt + 1'b1;
        end else state_nxt = o_Switch == 4'b1111 ? ARM_RST : IDLE;
      ARM_RST:
        if (o_Switch == 4'b1111) begin
          state_nxt = hold_last ? LOCKOUT : ARM_RST;
          hold_nxt = hold_last ? '0 : hold_cnt + 1'b1;
        end else state_nxt = IDLE;
      default: state_nxt = o_Switch == 4'b0000 ? IDLE : LOCKOUT;
    endcase
  end
  // strobe decode: game-reset over start over a single freshly-risen direction in IDLE
  always_comb begin
    fire_rst = state == ARM_RST && o_Switch == 4'b1111 && hold_last;
    fire_start = state == ARM_START && o_Switch == 4'b0111 && hold_last;
    dir = (state == IDLE && !fire_rst && !fire_start && $onehot(o_Switch)) ? o_Switch & ~sw_q : 4'b0000;
  end
  // registered one-cycle strobes and previous debounced level for edge detection
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      sw_q <= '0;
      {o_Rt_Pulse, o_Lt_Pulse, o_Dn_Pulse, o_Up_Pulse} <= '0;
      o_Start <= 1'b0;
      o_Game_Reset <= 1'b0;
    end else begin
      sw_q <= o_Switch;
      {o_Rt_Pulse, o_Lt_Pulse, o_Dn_Pulse, o_Up_Pulse} <= dir;
      o_Start <= fire_start;
      o_Game_Reset <= fire_rst;
    end
endmodule

// File: tb/tb_button_decoder.sv
// tb_button_decoder: directed checks of debounce, direction strobes, combos and reset abort
module tb_button_decoder;
  logic i_Clk = 1'b0;
  logic i_Reset_n = 1'b0;
  logic [3:0] i_Switch = 4'b0000;
  logic [3:0] o_Switch;
  logic o_Up_Pulse, o_Dn_Pulse, o_Lt_Pulse, o_Rt_Pulse, o_Start, o_Game_Reset, o_Combo_Active;
  int checks = 0, errors = 0;
  int n_up = 0, n_dn = 0, n_lt = 0, n_rt = 0, n_st = 0, n_gr = 0, multi = 0;
  int b_up, b_dn, b_lt, b_rt, b_st, b_gr;
  button_decoder #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8)) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Switch(i_Switch), .o_Switch(o_Switch),
    .o_Up_Pulse(o_Up_Pulse), .o_Dn_Pulse(o_Dn_Pulse), .o_Lt_Pulse(o_Lt_Pulse),
    .o_Rt_Pulse(o_Rt_Pulse), .o_Start(o_Start), .o_Game_Reset(o_Game_Reset),
    .o_Combo_Active(o_Combo_Active)
  );
  always #5 i_Clk = ~i_Clk;
  // tally strobes and flag any cycle with more than one strobe high
  always @(negedge i_Clk) begin
    n_up += int'(o_Up_Pulse);
    n_dn += int'(o_Dn_Pulse);
    n_lt += int'(o_Lt_Pulse);
    n_rt += int'(o_Rt_Pulse);
    n_st += int'(o_Start);
    n_gr += int'(o_Game_Reset);
    if ($countones({o_Up_Pulse, o_Dn_Pulse, o_Lt_Pulse, o_Rt_Pulse, o_Start, o_Game_Reset}) > 1) multi += 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    b_up = n_up; b_dn = n_dn; b_lt = n_lt; b_rt = n_rt; b_st = n_st; b_gr = n_gr;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge i_Clk);
  endtask
  function automatic logic [31:0] all_out();
    return 32'({o_Switch, o_Up_Pulse, o_Dn_Pulse, o_Lt_Pulse, o_Rt_Pulse, o_Start, o_Game_Reset, o_Combo_Active});
  endfunction
  initial begin
    idle(3);
    chk("reset_outputs", all_out(), 32'd0);
    i_Reset_n = 1'b1;
    idle(2);
    // clean press of up
    snap();
    i_Switch = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_Clk);
      chk("t1_sw", 32'(o_Switch), c >= 6 ? 32'd1 : 32'd0);
      chk("t1_up", 32'(o_Up_Pulse), 32'(c == 7));
    end
    i_Switch = 4'b0000;
    idle(10);
    chk("t1_sw_released", 32'(o_Switch), 32'd0);
    chk("t1_up_count", 32'(n_up - b_up), 32'd1);
    chk("t1_other_count", 32'((n_dn - b_dn) + (n_lt - b_lt) + (n_rt - b_rt) + (n_st - b_st) + (n_gr - b_gr)), 32'd0);
    // bouncing left switch never accepted
    snap();
    for (int c = 0; c < 30; c++) begin
      i_Switch = ((c / 3) % 2 == 0) ? 4'b0100 : 4'b0000;
      @(negedge i_Clk);
      chk("t2_sw", 32'(o_Switch), 32'd0);
    end
    i_Switch = 4'b0000;
    idle(10);
    chk("t2_pulse_count", 32'((n_up - b_up) + (n_dn - b_dn) + (n_lt - b_lt) + (n_rt - b_rt) + (n_st - b_st) + (n_gr - b_gr)), 32'd0);
    // start combo
    snap();
    i_Switch = 4'b0111;
    for (int c = 1; c <= 30; c++) begin
      @(negedge i_Clk);
      chk("t3_start", 32'(o_Start), 32'(c == 15));
      chk("t3_active", 32'(o_Combo_Active), 32'(c >= 7));
    end
    chk("t3_sw", 32'(o_Switch), 32'h7);
    chk("t3_start_count", 32'(n_st - b_st), 32'd1);
    chk("t3_dir_count", 32'((n_up - b_up) + (n_dn - b_dn) + (n_lt - b_lt) + (n_rt - b_rt) + (n_gr - b_gr)), 32'd0);
    i_Switch = 4'b0000;
    idle(8);
    chk("t3_idle", 32'(o_Combo_Active), 32'd0);
    // start combo upgraded to game reset, then held long
    snap();
    i_Switch = 4'b0111;
    for (int c = 1; c <= 130; c++) begin
      @(negedge i_Clk);
      chk("t4_game_reset", 32'(o_Game_Reset), 32'(c == 22));
      chk("t4_start", 32'(o_Start), 32'd0);
      if (c == 12) chk("t4_sw_start", 32'(o_Switch), 32'h7);
      if (c == 13) chk("t4_sw_rst", 32'(o_Switch), 32'hf);
      if (c == 7) i_Switch = 4'b1111;
    end
    chk("t4_gr_count", 32'(n_gr - b_gr), 32'd1);
    chk("t4_other_count", 32'((n_up - b_up) + (n_dn - b_dn) + (n_lt - b_lt) + (n_rt - b_rt) + (n_st - b_st)), 32'd0);
    i_Switch = 4'b0000;
    idle(10);
    chk("t4_idle", 32'(o_Combo_Active), 32'd0);
    // reset mid-hold in ARM_RST, then fresh debounce with switches still held
    snap();
    i_Switch = 4'b1111;
    idle(12);
    chk("t5_armed", 32'(o_Combo_Active), 32'd1);
    i_Reset_n = 1'b0;
    #1;
    chk("t5_async_clear", all_out(), 32'd0);
    @(negedge i_Clk);
    chk("t5_in_reset", all_out(), 32'd0);
    i_Reset_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_Clk);
      chk("t5_sw", 32'(o_Switch), c >= 6 ? 32'hf : 32'd0);
      chk("t5_game_reset", 32'(o_Game_Reset), 32'(c == 15));
    end
    chk("t5_gr_count", 32'(n_gr - b_gr), 32'd1);
    chk("t5_other_count", 32'((n_up - b_up) + (n_dn - b_dn) + (n_lt - b_lt) + (n_rt - b_rt) + (n_st - b_st)), 32'd0);
    i_Switch = 4'b0000;
    idle(10);
    chk("t5_idle", 32'(o_Combo_Active), 32'd0);
    // up held, right added: second press is not a single-switch press
    snap();
    i_Switch = 4'b0001;
    for (int c = 1; c <= 25; c++) begin
      @(negedge i_Clk);
      chk("t6_up", 32'(o_Up_Pulse), 32'(c == 7));
      chk("t6_rt", 32'(o_Rt_Pulse), 32'd0);
      if (c == 10) i_Switch = 4'b1001;
    end
    chk("t6_sw", 32'(o_Switch), 32'h9);
    chk("t6_up_count", 32'(n_up - b_up), 32'd1);
    chk("t6_other_count", 32'((n_dn - b_dn) + (n_lt - b_lt) + (n_rt - b_rt) + (n_st - b_st) + (n_gr - b_gr)), 32'd0);
    i_Switch = 4'b0000;
    idle(10);
    chk("single_strobe", 32'(multi), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
